// File: rtl/branch_sequencer_pkg.sv
// Shared constants for the branch sequencer: branch funct codes and FSM states.
package branch_pkg;

    // Branch funct field encodings (instr[11:8])
    localparam logic [3:0] FUNCT_BEQ = 4'b0000;
    localparam logic [3:0] FUNCT_BNE = 4'b0001;
    localparam logic [3:0] FUNCT_BCS = 4'b0010;
    localparam logic [3:0] FUNCT_BCC = 4'b0011;
    localparam logic [3:0] FUNCT_BAL = 4'b1110;

    // Sequencer FSM states
    localparam logic [1:0] ST_RUN        = 2'd0;
    localparam logic [1:0] ST_WAIT_FLAGS = 2'd1;
    localparam logic [1:0] ST_RESOLVE    = 2'd2;

endpackage

// File: rtl/branch_sequencer_cond_eval.sv
// Combinational branch condition decoder: maps funct and the C/Z flags to a
// taken decision, a link-write request and an illegal-funct indication.
module branch_cond_eval
    import branch_pkg::*;
(
    input  logic [3:0] funct,
    input  logic       c,
    input  logic       z,
    output logic       taken,
    output logic       is_link,
    output logic       illegal
);

    // Decode the branch form; undefined functs are never taken
    always_comb begin
        taken   = 1'b0;
        is_link = 1'b0;
        illegal = 1'b0;
        case (funct)
            FUNCT_BEQ: taken = z;
            FUNCT_BNE: taken = ~z;
            FUNCT_BCS: taken = c;
            FUNCT_BCC: taken = ~c;
            FUNCT_BAL: begin
                taken   = 1'b1;
                is_link = 1'b1;
            end
            default:   illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_sequencer.sv
// PC owner and branch resolver between fetch and the decoder's branch logic.
// Optional feature: define BRANCH_STATS_EN to add saturating taken/not-taken
// counters (taken_cnt, not_taken_cnt).
module branch_sequencer
    import branch_pkg::*;
#(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
)
(
    input  logic            clk,
    input  logic            rst,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [15:0]     instr,
    input  logic            is_branch,
    input  logic            flag_we,
    input  logic            c_in,
    input  logic            z_in,
    input  logic            flag_pending,
    output logic [PC_W-1:0] pc,
    output logic            flush,
    output logic            link_we,
    output logic [PC_W-1:0] link_data,
    output logic            illegal
`ifdef BRANCH_STATS_EN
    ,
    output logic [15:0]     taken_cnt,
    output logic [15:0]     not_taken_cnt
`endif
);

    localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

    logic [1:0]      state;
    logic            c_flag;
    logic            z_flag;
    logic [PC_W-1:0] pc_br;
    logic [3:0]      funct_r;
    logic [7:0]      offset_r;

    logic            accept;
    logic            resolving;
    logic            eval_c;
    logic            eval_z;
    logic            cond_taken;
    logic            cond_link;
    logic            cond_illegal;
    logic [PC_W-1:0] offset_ext;
    logic [PC_W-1:0] pc_seq;
    logic [PC_W-1:0] pc_target;
    logic            unused_instr_hi;

    assign unused_instr_hi = ^instr[15:12];

    assign accept     = instr_valid && instr_ready;
    assign resolving  = (state == ST_RESOLVE) && !rst;

    // A flag write landing in the resolve cycle is forwarded to the condition
    assign eval_c     = flag_we ? c_in : c_flag;
    assign eval_z     = flag_we ? z_in : z_flag;

    assign offset_ext = {{(PC_W-8){offset_r[7]}}, offset_r};
    assign pc_seq     = pc_br + PC_ONE;
    assign pc_target  = pc_seq + offset_ext;

    branch_cond_eval u_cond (
        .funct   (funct_r),
        .c       (eval_c),
        .z       (eval_z),
        .taken   (cond_taken),
        .is_link (cond_link),
        .illegal (cond_illegal)
    );

    // Handshake and resolve-cycle strobes; reset suppresses an in-flight branch
    always_comb begin
        instr_ready = (state == ST_RUN) && !rst;
        flush       = resolving && cond_taken;
        link_we     = resolving && cond_link;
        illegal     = resolving && cond_illegal;
        link_data   = (resolving && cond_link) ? pc_seq : '0;
    end

    // Flag register, PC and branch-capture FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_RUN;
            pc       <= RESET_PC;
            c_flag   <= 1'b0;
            z_flag   <= 1'b0;
            pc_br    <= '0;
            funct_r  <= '0;
            offset_r <= '0;
        end else begin
            if (flag_we) begin
                c_flag <= c_in;
                z_flag <= z_in;
            end
            case (state)
                ST_RUN: begin
                    if (accept) begin
                        if (is_branch) begin
                            pc_br    <= pc;
                            funct_r  <= instr[11:8];
                            offset_r <= instr[7:0];
                            state    <= flag_pending ? ST_WAIT_FLAGS : ST_RESOLVE;
                        end else begin
                            pc <= pc + PC_ONE;
                        end
                    end
                end
                ST_WAIT_FLAGS: begin
                    if (!flag_pending) begin
                        state <= ST_RESOLVE;
                    end
                end
                ST_RESOLVE: begin
                    pc    <= cond_taken ? pc_target : pc_seq;
                    state <= ST_RUN;
                end
                default: state <= ST_RUN;
            endcase
        end
    end

`ifdef BRANCH_STATS_EN
    // Saturating outcome counters; illegal branches count as not taken
    always_ff @(posedge clk) begin
        if (rst) begin
            taken_cnt     <= '0;
            not_taken_cnt <= '0;
        end else if (resolving) begin
            if (cond_taken) begin
                if (taken_cnt != 16'hFFFF) taken_cnt <= taken_cnt + 16'd1;
            end else begin
                if (not_taken_cnt != 16'hFFFF) not_taken_cnt <= not_taken_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_sequencer.sv
// Scoreboard bench for branch_sequencer: a driver steps a behavioural model
// and queues expected accepts and resolve strobes; a monitor compares them.
module tb_branch_sequencer;

    typedef struct {
        int          cyc;
        logic        flush;
        logic        link_we;
        logic        illegal;
        logic [15:0] link_data;
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [15:0] instr = '0;
    logic        is_branch = 1'b0;
    logic        flag_we = 1'b0;
    logic        c_in = 1'b0;
    logic        z_in = 1'b0;
    logic        flag_pending = 1'b0;
    logic [15:0] pc;
    logic        flush;
    logic        link_we;
    logic [15:0] link_data;
    logic        illegal;
`ifdef BRANCH_STATS_EN
    logic [15:0] taken_cnt;
    logic [15:0] not_taken_cnt;
`endif

    int          cycle = 0;
    int          checks = 0;
    int          fails = 0;
    bit          exp_ready = 1'b1;
    logic [15:0] acc_q[$];
    res_t        res_q[$];

    logic [15:0] m_pc = '0;
    bit          m_c = 1'b0;
    bit          m_z = 1'b0;
    int          m_taken = 0;
    int          m_not_taken = 0;

    branch_sequencer #(.PC_W(16), .RESET_PC(16'h0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr        (instr),
        .is_branch    (is_branch),
        .flag_we      (flag_we),
        .c_in         (c_in),
        .z_in         (z_in),
        .flag_pending (flag_pending),
        .pc           (pc),
        .flush        (flush),
        .link_we      (link_we),
        .link_data    (link_data),
        .illegal      (illegal)
`ifdef BRANCH_STATS_EN
        ,
        .taken_cnt     (taken_cnt),
        .not_taken_cnt (not_taken_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Monitor: compare handshake, accepted PC and resolve strobes each cycle
    always @(negedge clk) begin
        res_t r;
        if (rst) begin
            check("reset_strobes", {29'd0, flush, link_we, illegal}, 32'd0);
            check("reset_link_data", {16'd0, link_data}, 32'd0);
        end else begin
            check("instr_ready", {31'd0, instr_ready}, {31'd0, exp_ready});
            if (instr_valid && instr_ready) begin
                if (acc_q.size() == 0) begin
                    check("unexpected_accept", 32'd1, 32'd0);
                end else begin
                    check("pc_at_accept", {16'd0, pc}, {16'd0, acc_q.pop_front()});
                end
            end
            if (res_q.size() > 0 && res_q[0].cyc == cycle) begin
                r = res_q.pop_front();
                check("flush", {31'd0, flush}, {31'd0, r.flush});
                check("link_we", {31'd0, link_we}, {31'd0, r.link_we});
                check("illegal", {31'd0, illegal}, {31'd0, r.illegal});
                check("link_data", {16'd0, link_data}, {16'd0, r.link_data});
            end else begin
                check("idle_strobes", {29'd0, flush, link_we, illegal}, 32'd0);
                check("idle_link_data", {16'd0, link_data}, 32'd0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Branch outcome from the architectural rules
    function automatic void model_eval(input logic [3:0] fn, input bit c, input bit z,
                                       output bit tk, output bit lk, output bit il);
        tk = 1'b0; lk = 1'b0; il = 1'b0;
        case (fn)
            4'b0000: tk = z;
            4'b0001: tk = !z;
            4'b0010: tk = c;
            4'b0011: tk = !c;
            4'b1110: begin tk = 1'b1; lk = 1'b1; end
            default: il = 1'b1;
        endcase
    endfunction

    task automatic drive_flags(input bit rnd);
        flag_we = rnd ? 1'($urandom) : 1'b0;
        c_in    = rnd ? 1'($urandom) : 1'b0;
        z_in    = rnd ? 1'($urandom) : 1'b0;
    endtask

    task automatic apply_flags();
        if (flag_we) begin
            m_c = c_in;
            m_z = z_in;
        end
    endtask

    task automatic busy_inputs(input bit rnd);
        exp_ready   = 1'b0;
        instr_valid = rnd ? 1'($urandom) : 1'b0;
        instr       = 16'($urandom);
        is_branch   = 1'($urandom);
    endtask

    task automatic idle(input bit rnd);
        exp_ready    = 1'b1;
        instr_valid  = 1'b0;
        flag_pending = rnd ? 1'($urandom) : 1'b0;
        drive_flags(rnd);
        apply_flags();
        step();
    endtask

    task automatic write_flags(input bit c, input bit z);
        exp_ready    = 1'b1;
        instr_valid  = 1'b0;
        flag_pending = 1'b0;
        flag_we = 1'b1; c_in = c; z_in = z;
        apply_flags();
        step();
        flag_we = 1'b0;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        instr_valid = 1'b0; flag_we = 1'b0; flag_pending = 1'b0;
        step();
        step();
        rst = 1'b0;
        m_pc = 16'h0000; m_c = 1'b0; m_z = 1'b0;
        m_taken = 0; m_not_taken = 0;
        exp_ready = 1'b1;
    endtask

    task automatic check_pc_now(input string name);
        exp_ready   = 1'b1;
        instr_valid = 1'b0;
        flag_we     = 1'b0;
        @(negedge clk);
        check(name, {16'd0, pc}, {16'd0, m_pc});
        @(posedge clk);
        #1;
    endtask

    // Issue one instruction and walk it to completion through the model
    task automatic applyStimulus(input bit br, input logic [3:0] fn, input logic [7:0] off,
                                 input int pend, input bit rnd, input bit rel_we, input bit rel_z);
        bit   ec, ez, tk, lk, il;
        res_t r;
        exp_ready    = 1'b1;
        instr_valid  = 1'b1;
        instr        = {4'($urandom), fn, off};
        is_branch    = br;
        flag_pending = br ? (pend > 0) : (rnd ? 1'($urandom) : 1'b0);
        drive_flags(rnd);
        acc_q.push_back(m_pc);
        apply_flags();
        if (!br) m_pc = m_pc + 16'd1;
        step();
        if (!br) return;
        for (int k = 1; k < pend; k++) begin
            busy_inputs(rnd);
            flag_pending = 1'b1;
            drive_flags(rnd);
            apply_flags();
            step();
        end
        if (pend > 0) begin
            busy_inputs(rnd);
            flag_pending = 1'b0;
            if (rnd) drive_flags(1'b1);
            else begin flag_we = rel_we; c_in = 1'b0; z_in = rel_z; end
            apply_flags();
            step();
        end
        busy_inputs(rnd);
        flag_pending = rnd ? 1'($urandom) : 1'b0;
        drive_flags(rnd);
        ec = flag_we ? c_in : m_c;
        ez = flag_we ? z_in : m_z;
        model_eval(fn, ec, ez, tk, lk, il);
        r.cyc = cycle; r.flush = tk; r.link_we = lk; r.illegal = il;
        r.link_data = lk ? m_pc + 16'd1 : 16'd0;
        res_q.push_back(r);
        apply_flags();
        m_pc = tk ? m_pc + 16'd1 + {{8{off[7]}}, off} : m_pc + 16'd1;
        if (tk) m_taken++; else m_not_taken++;
        step();
        flag_we = 1'b0;
    endtask

    // End-of-run checks: scoreboard drained, final PC and optional counters
    task automatic checkOutput();
        check("accept_queue_drained", acc_q.size(), 32'd0);
        check("resolve_queue_drained", res_q.size(), 32'd0);
        check_pc_now("final_pc");
`ifdef BRANCH_STATS_EN
        check("taken_cnt", {16'd0, taken_cnt}, m_taken);
        check("not_taken_cnt", {16'd0, not_taken_cnt}, m_not_taken);
`endif
    endtask

    initial begin
        logic [3:0] fn;
        int         pend;
        step();
        reset_dut();
        check_pc_now("reset_pc");

        // Back-to-back non-branches, then taken BEQ at pc=5
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 4'h0, 8'h00, 0, 1'b0, 1'b0, 1'b0);
        check_pc_now("pc_after_5_seq");
        write_flags(1'b0, 1'b1);
        applyStimulus(1'b1, 4'b0000, 8'h03, 0, 1'b0, 1'b0, 1'b0);
        check_pc_now("pc_after_beq");

        // Not-taken BCC at pc=5 with C=1
        reset_dut();
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 4'h0, 8'h00, 0, 1'b0, 1'b0, 1'b0);
        write_flags(1'b1, 1'b0);
        applyStimulus(1'b1, 4'b0011, 8'h40, 0, 1'b0, 1'b0, 1'b0);
        check_pc_now("pc_after_bcc");

        // BAL wrapping below zero, then BAL at 16'hFFFE
        reset_dut();
        applyStimulus(1'b1, 4'b1110, 8'hFD, 0, 1'b0, 1'b0, 1'b0);
        check_pc_now("pc_after_bal_wrap");
        applyStimulus(1'b1, 4'b1110, 8'hFE, 0, 1'b0, 1'b0, 1'b0);
        check_pc_now("pc_after_bal_fffe");

        // BNE waiting on flags; release cycle writes Z=0
        write_flags(1'b0, 1'b1);
        applyStimulus(1'b1, 4'b0001, 8'h10, 3, 1'b0, 1'b1, 1'b0);
        check_pc_now("pc_after_bne_wait");

        // Undefined funct
        applyStimulus(1'b1, 4'b0101, 8'h22, 0, 1'b0, 1'b0, 1'b0);
        check_pc_now("pc_after_illegal");
`ifdef BRANCH_STATS_EN
        check("not_taken_cnt_illegal", {16'd0, not_taken_cnt}, m_not_taken);
`endif

        // Reset landing on the resolve cycle discards the branch
        applyStimulus(1'b0, 4'h0, 8'h00, 0, 1'b0, 1'b0, 1'b0);
        exp_ready = 1'b1; instr_valid = 1'b1; is_branch = 1'b1;
        instr = {4'h0, 4'b1110, 8'h20}; flag_pending = 1'b0; flag_we = 1'b0;
        acc_q.push_back(m_pc);
        step();
        reset_dut();
        check_pc_now("pc_after_mid_reset");

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 4) == 0) idle(1'b1);
            if ($urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 5))
                    0: fn = 4'b0000;
                    1: fn = 4'b0001;
                    2: fn = 4'b0010;
                    3: fn = 4'b0011;
                    4: fn = 4'b1110;
                    default: fn = 4'($urandom);
                endcase
                pend = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 4);
                applyStimulus(1'b1, fn, 8'($urandom), pend, 1'b1, 1'b0, 1'b0);
            end else begin
                applyStimulus(1'b0, 4'($urandom), 8'($urandom), 0, 1'b1, 1'b0, 1'b0);
            end
        end
        idle(1'b0);
        idle(1'b0);
        checkOutput();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
